// File: rtl/pp_ctrl_pkg.sv
// Shared opcodes and FSM encoding for the ping-pong sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pp_ctrl_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_START  = 3'd1;
    localparam logic [2:0] OP_STOP   = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_SET_LO = 3'd4;
    localparam logic [2:0] OP_SET_HI = 3'd5;
    localparam logic [2:0] OP_SET_DIV = 3'd6;
    localparam logic [2:0] OP_CLEAR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

endpackage

// File: rtl/ping_pong_sequencer_if.sv
// Command port plus counter status bundle of the ping-pong sequencer.
// Latency: n/a (wires only).
// Backpressure: cmd_ready gates command acceptance.
interface ping_pong_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [7:0]       cmd_arg;
    logic [WIDTH-1:0] count;
    logic             direction;
    logic             running;
    logic             bounce;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_arg,
        input  cmd_ready, count, direction, running, bounce, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg,
        output cmd_ready, count, direction, running, bounce, err
    );
endinterface

// File: rtl/ping_pong_core.sv
// Bounded up/down counter that turns around at lo/hi and clamps out-of-range values.
// Latency: one cycle from adv/clr to count/direction/bounce.
// Backpressure: none; adv and clr are consumed every cycle they are high.
module ping_pong_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             clr,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] count,
    output logic             direction,
    output logic             bounce
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            direction <= 1'b1;
            bounce    <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (clr) begin
                count     <= lo;
                direction <= 1'b1;
            end else if (adv) begin
                if (count > hi) begin
                    count     <= hi;
                    direction <= 1'b0;
                end else if (count < lo) begin
                    count     <= lo;
                    direction <= 1'b1;
                end else if (lo == hi) begin
                    // Zero-width window: nowhere to move, and hi-1/lo+1 would leave it.
                    count <= count;
                end else if (direction && (count == hi)) begin
                    count     <= hi - 1'b1;
                    direction <= 1'b0;
                    bounce    <= 1'b1;
                end else if (!direction && (count == lo)) begin
                    count     <= lo + 1'b1;
                    direction <= 1'b1;
                    bounce    <= 1'b1;
                end else if (direction) begin
                    count <= count + 1'b1;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ping_pong_sequencer.sv
// Command decoder, bound/prescaler registers and IDLE/RUN/STEP FSM around ping_pong_core.
// Latency: accepted command visible on outputs one cycle later.
// Backpressure: cmd_ready drops for the single STEP cycle only.
module ping_pong_sequencer
    import pp_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ping_pong_sequencer_if.slave  bus
);

    state_e             state, state_n;
    logic [WIDTH-1:0]   lo, lo_n, hi, hi_n;
    logic [DIV_W-1:0]   div, div_n, presc, presc_n;
    logic               err_n, adv, clr, acc, tick;

    assign bus.cmd_ready = (state != ST_STEP);
    assign bus.running   = (state == ST_RUN);
    assign acc           = bus.cmd_valid & bus.cmd_ready;
    assign tick          = (presc == div);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lo      <= '0;
            hi      <= '1;
            div     <= '0;
            presc   <= '0;
            bus.err <= 1'b0;
        end else begin
            state   <= state_n;
            lo      <= lo_n;
            hi      <= hi_n;
            div     <= div_n;
            presc   <= presc_n;
            bus.err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        lo_n    = lo;
        hi_n    = hi;
        div_n   = div;
        presc_n = '0;
        err_n   = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc) begin
                    case (bus.cmd_op)
                        OP_START:   if (lo < hi) state_n = ST_RUN; else err_n = 1'b1;
                        OP_STEP:    state_n = ST_STEP;
                        OP_SET_LO:  lo_n  = bus.cmd_arg[WIDTH-1:0];
                        OP_SET_HI:  hi_n  = bus.cmd_arg[WIDTH-1:0];
                        OP_SET_DIV: div_n = bus.cmd_arg[DIV_W-1:0];
                        OP_CLEAR:   clr   = 1'b1;
                        default:    ;
                    endcase
                end
            end
            ST_RUN: begin
                // STOP/CLEAR take effect immediately and pre-empt a coincident tick.
                if (acc && (bus.cmd_op == OP_STOP)) begin
                    state_n = ST_IDLE;
                end else if (acc && (bus.cmd_op == OP_CLEAR)) begin
                    clr     = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    adv     = tick;
                    presc_n = tick ? '0 : presc + 1'b1;
                    if (acc && (bus.cmd_op inside {OP_STEP, OP_SET_LO, OP_SET_HI, OP_SET_DIV}))
                        err_n = 1'b1;
                end
            end
            ST_STEP: begin
                adv     = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    ping_pong_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .clr       (clr),
        .lo        (lo),
        .hi        (hi),
        .count     (bus.count),
        .direction (bus.direction),
        .bounce    (bus.bounce)
    );

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Directed scenarios plus random commands, every cycle compared against a behavioural model.
module tb_ping_pong_sequencer;
    import pp_ctrl_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    // reference model state
    bit m_run, m_step, m_dir, m_bnc, m_err;
    int m_lo, m_hi, m_div, m_ph, m_cnt;

    ping_pong_sequencer_if #(.WIDTH(W)) bus();

    ping_pong_sequencer #(.WIDTH(W), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One ping-pong move from the rule table, on plain integers.
    task automatic move(inout int c, inout bit d, output bit b);
        b = 1'b0;
        if (c > m_hi)               begin c = m_hi; d = 0; end
        else if (c < m_lo)          begin c = m_lo; d = 1; end
        else if (m_lo == m_hi)      begin end
        else if (d && c == m_hi)    begin c = m_hi - 1; d = 0; b = 1; end
        else if (!d && c == m_lo)   begin c = m_lo + 1; d = 1; b = 1; end
        else                        c = d ? c + 1 : c - 1;
    endtask

    task automatic model_next(input bit r, input bit v, input int op, input int arg);
        bit acc, b;
        int c;
        bit d;
        c = m_cnt; d = m_dir; b = 0;
        m_err = 0;
        if (r) begin
            m_run = 0; m_step = 0; m_lo = 0; m_hi = (1 << W) - 1; m_div = 0;
            m_ph = 0; m_cnt = 0; m_dir = 1; m_bnc = 0;
            return;
        end
        acc = v && !m_step;
        if (m_step) begin
            move(c, d, b);
            m_step = 0;
        end else if (m_run) begin
            if (acc && op == OP_STOP) begin
                m_run = 0; m_ph = 0;
            end else if (acc && op == OP_CLEAR) begin
                m_run = 0; m_ph = 0; c = m_lo; d = 1;
            end else begin
                if (acc && op >= OP_STEP && op != OP_CLEAR) m_err = 1;
                if (m_ph == m_div) begin
                    move(c, d, b);
                    m_ph = 0;
                end else m_ph++;
            end
        end else if (acc) begin
            case (op)
                OP_START:   if (m_lo < m_hi) m_run = 1; else m_err = 1;
                OP_STEP:    m_step = 1;
                OP_SET_LO:  m_lo = arg % (1 << W);
                OP_SET_HI:  m_hi = arg % (1 << W);
                OP_SET_DIV: m_div = arg;
                OP_CLEAR:   begin c = m_lo; d = 1; end
                default:    ;
            endcase
        end
        m_cnt = c; m_dir = d; m_bnc = b;
    endtask

    task automatic cyc(input bit r, input bit v, input logic [2:0] op, input logic [7:0] arg);
        rst_n         = !r;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        model_next(r, v, int'(op), int'(arg));
        @(posedge clk);
        @(negedge clk);
        chk("count",     int'(bus.count),     m_cnt);
        chk("direction", int'(bus.direction), int'(m_dir));
        chk("running",   int'(bus.running),   int'(m_run));
        chk("bounce",    int'(bus.bounce),    int'(m_bnc));
        chk("err",       int'(bus.err),       int'(m_err));
        chk("cmd_ready", int'(bus.cmd_ready), int'(!m_step));
    endtask

    task automatic cmd(input logic [2:0] op, input logic [7:0] arg);
        cyc(1'b0, 1'b1, op, arg);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, OP_NOP, 8'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_arg   = 8'd0;
        @(negedge clk);

        // reset state
        cyc(1'b1, 1'b0, OP_NOP, 8'd0);
        cyc(1'b1, 1'b0, OP_NOP, 8'd0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_dir", int'(bus.direction), 1);

        // full-range bounce, div=0
        cmd(OP_START, 8'd0);
        chk("t1_run", int'(bus.running), 1);
        idle_n(15);
        chk("t1_top", int'(bus.count), 15);
        idle_n(1);
        chk("t1_turn", int'(bus.count), 14);
        chk("t1_bounce", int'(bus.bounce), 1);
        chk("t1_dir", int'(bus.direction), 0);
        idle_n(15);
        chk("t1_bottom_bounce", int'(bus.bounce), 1);
        chk("t1_bottom_cnt", int'(bus.count), 1);

        // narrow window with prescaler
        cyc(1'b1, 1'b0, OP_NOP, 8'd0);
        cmd(OP_SET_LO, 8'd3);
        cmd(OP_SET_HI, 8'd6);
        cmd(OP_SET_DIV, 8'd2);
        cmd(OP_START, 8'd0);
        idle_n(2);
        chk("t2_wait", int'(bus.count), 0);
        idle_n(1);
        chk("t2_clamp", int'(bus.count), 3);
        chk("t2_clamp_nobounce", int'(bus.bounce), 0);
        idle_n(9);
        chk("t2_hi", int'(bus.count), 6);
        idle_n(3);
        chk("t2_turn", int'(bus.count), 5);
        chk("t2_bounce", int'(bus.bounce), 1);

        // degenerate bounds, START rejected, STEP still moves
        cmd(OP_STOP, 8'd0);
        cmd(OP_CLEAR, 8'd0);
        chk("t3_clear", int'(bus.count), 3);
        cmd(OP_SET_LO, 8'd5);
        cmd(OP_SET_HI, 8'd5);
        cmd(OP_START, 8'd0);
        chk("t3_err", int'(bus.err), 1);
        chk("t3_norun", int'(bus.running), 0);
        cmd(OP_STEP, 8'd0);
        chk("t3_busy", int'(bus.cmd_ready), 0);
        idle_n(1);
        chk("t3_step", int'(bus.count), 5);
        chk("t3_ready", int'(bus.cmd_ready), 1);

        // rejected commands during RUN, STOP freezes, CLEAR reloads
        cmd(OP_SET_LO, 8'd2);
        cmd(OP_SET_HI, 8'd8);
        cmd(OP_START, 8'd0);
        idle_n(6);
        chk("t4_cnt", int'(bus.count), 7);
        cmd(OP_SET_HI, 8'd9);
        chk("t4_sethi_err", int'(bus.err), 1);
        cmd(OP_STEP, 8'd0);
        chk("t4_step_err", int'(bus.err), 1);
        cmd(OP_STOP, 8'd0);
        chk("t4_stopped", int'(bus.running), 0);
        idle_n(3);
        chk("t4_frozen", int'(bus.count), 7);
        cmd(OP_CLEAR, 8'd0);
        chk("t4_clr_cnt", int'(bus.count), 2);
        chk("t4_clr_dir", int'(bus.direction), 1);

        // reset beats a simultaneous START mid-RUN
        cmd(OP_START, 8'd0);
        idle_n(2);
        cyc(1'b1, 1'b1, OP_START, 8'd0);
        chk("t5_cnt", int'(bus.count), 0);
        chk("t5_run", int'(bus.running), 0);

        // STEP held valid: ready alternates, two steps taken
        cmd(OP_STEP, 8'd0);
        chk("t6_r0", int'(bus.cmd_ready), 0);
        cmd(OP_STEP, 8'd0);
        chk("t6_r1", int'(bus.cmd_ready), 1);
        cmd(OP_STEP, 8'd0);
        chk("t6_r2", int'(bus.cmd_ready), 0);
        cmd(OP_STEP, 8'd0);
        chk("t6_cnt", int'(bus.count), 2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            logic [7:0] arg;
            op  = 3'($urandom_range(0, 7));
            arg = (op == OP_SET_DIV) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, op, arg);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
